// File: rtl/dds_burst_ctrl.sv
// Burst scheduler for the DDS output path: start delay, then ON periods and OFF gaps,
// repeated a programmable number of times, with a phase-reset strobe on every ON entry.
module dds_burst_ctrl #(
    parameter int CNT_W = 16,
    parameter int REP_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic             START,
    input  logic             STOP,
    input  logic [CNT_W-1:0] DELAY_CYC,
    input  logic [CNT_W-1:0] ON_CYC,
    input  logic [CNT_W-1:0] OFF_CYC,
    input  logic [REP_W-1:0] REPEAT,
    output logic             DDS_EN,
    output logic             PHASE_RST,
    output logic             BUSY,
    output logic             DONE,
    output logic [REP_W-1:0] BURST_IDX
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_ON,
        S_OFF
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   on_q, on_d;
    logic [CNT_W-1:0]   off_q, off_d;
    logic [REP_W-1:0]   rep_q, rep_d;
    logic [REP_W-1:0]   idx_q, idx_d;
    logic               dds_en_q, dds_en_d;
    logic               phase_rst_q, phase_rst_d;
    logic               done_q, done_d;

    logic               cnt_last;
    logic               last_burst;

    // Counters load N and finish on the edge that sees 1, so N = 2^CNT_W-1 fits without overflow.
    assign cnt_last   = (cnt_q == CNT_W'(1));
    assign last_burst = (rep_q != '0) && (idx_q == rep_q - REP_W'(1));

    always_comb begin
        // NOTE: every signal gets a hold/default value first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        on_d        = on_q;
        off_d       = off_q;
        rep_d       = rep_q;
        idx_d       = idx_q;
        dds_en_d    = dds_en_q;
        phase_rst_d = phase_rst_q;
        done_d      = done_q;

        if (CE) begin
            phase_rst_d = 1'b0;
            done_d      = 1'b0;
            if (STOP) begin
                state_d  = S_IDLE;
                cnt_d    = '0;
                dds_en_d = 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (START && (ON_CYC != '0)) begin
                            on_d  = ON_CYC;
                            off_d = OFF_CYC;
                            rep_d = REPEAT;
                            idx_d = '0;
                            if (DELAY_CYC == '0) begin
                                state_d     = S_ON;
                                cnt_d       = ON_CYC;
                                dds_en_d    = 1'b1;
                                phase_rst_d = 1'b1;
                            end else begin
                                state_d = S_DELAY;
                                cnt_d   = DELAY_CYC;
                            end
                        end
                    end
                    S_DELAY: begin
                        if (cnt_last) begin
                            state_d     = S_ON;
                            cnt_d       = on_q;
                            dds_en_d    = 1'b1;
                            phase_rst_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    S_ON: begin
                        if (!cnt_last) begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end else if (last_burst) begin
                            state_d  = S_IDLE;
                            cnt_d    = '0;
                            dds_en_d = 1'b0;
                            done_d   = 1'b1;
                        end else if (off_q == '0) begin
                            cnt_d       = on_q;
                            phase_rst_d = 1'b1;
                            idx_d       = idx_q + REP_W'(1);
                        end else begin
                            state_d  = S_OFF;
                            cnt_d    = off_q;
                            dds_en_d = 1'b0;
                        end
                    end
                    S_OFF: begin
                        if (cnt_last) begin
                            state_d     = S_ON;
                            cnt_d       = on_q;
                            dds_en_d    = 1'b1;
                            phase_rst_d = 1'b1;
                            idx_d       = idx_q + REP_W'(1);
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            on_q        <= '0;
            off_q       <= '0;
            rep_q       <= '0;
            idx_q       <= '0;
            dds_en_q    <= 1'b0;
            phase_rst_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            on_q        <= on_d;
            off_q       <= off_d;
            rep_q       <= rep_d;
            idx_q       <= idx_d;
            dds_en_q    <= dds_en_d;
            phase_rst_q <= phase_rst_d;
            done_q      <= done_d;
        end
    end

    assign DDS_EN    = dds_en_q;
    assign PHASE_RST = phase_rst_q;
    assign BUSY      = (state_q != S_IDLE);
    assign DONE      = done_q;
    assign BURST_IDX = idx_q;

endmodule

// File: tb/tb_dds_burst_ctrl.sv
// Self-checking bench for dds_burst_ctrl: table-driven CE-edge vectors plus
// hand-written sequences for infinite repeat/wrap, STOP+START, async reset and ON_CYC=0.
module tb_dds_burst_ctrl;

    localparam int CNT_W = 16;
    localparam int REP_W = 8;

    logic             CLK;
    logic             RST;
    logic             CE;
    logic             START;
    logic             STOP;
    logic [CNT_W-1:0] DELAY_CYC;
    logic [CNT_W-1:0] ON_CYC;
    logic [CNT_W-1:0] OFF_CYC;
    logic [REP_W-1:0] REPEAT;
    logic             DDS_EN;
    logic             PHASE_RST;
    logic             BUSY;
    logic             DONE;
    logic [REP_W-1:0] BURST_IDX;

    dds_burst_ctrl #(.CNT_W(CNT_W), .REP_W(REP_W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CE        (CE),
        .START     (START),
        .STOP      (STOP),
        .DELAY_CYC (DELAY_CYC),
        .ON_CYC    (ON_CYC),
        .OFF_CYC   (OFF_CYC),
        .REPEAT    (REPEAT),
        .DDS_EN    (DDS_EN),
        .PHASE_RST (PHASE_RST),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .BURST_IDX (BURST_IDX)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic             ce;
        logic             start;
        logic             stop;
        logic             en;
        logic             ph;
        logic             busy;
        logic             done;
        logic [REP_W-1:0] idx;
    } vec_t;

    vec_t vq[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Output bundle packed as {DDS_EN, PHASE_RST, BUSY, DONE, BURST_IDX}.
    function automatic logic [11:0] outs();
        return {DDS_EN, PHASE_RST, BUSY, DONE, BURST_IDX};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got en/ph/busy/done/idx=%b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                      name, act[11], act[10], act[9], act[8], act[7:0],
                      exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    endtask

    task automatic step(input logic ce, input logic start, input logic stop);
        CE    = ce;
        START = start;
        STOP  = stop;
        @(posedge CLK);
        #1;
    endtask

    task automatic cfg(input int d, input int on, input int off, input int rep);
        DELAY_CYC = CNT_W'(d);
        ON_CYC    = CNT_W'(on);
        OFF_CYC   = CNT_W'(off);
        REPEAT    = REP_W'(rep);
    endtask

    function automatic void add(input logic ce, input logic start, input logic stop,
                                input logic en, input logic ph, input logic busy,
                                input logic done, input int idx);
        vec_t v;
        v.ce = ce; v.start = start; v.stop = stop;
        v.en = en; v.ph = ph; v.busy = busy; v.done = done; v.idx = REP_W'(idx);
        vq.push_back(v);
    endfunction

    task automatic run_table(input string name);
        foreach (vq[i]) begin
            step(vq[i].ce, vq[i].start, vq[i].stop);
            check($sformatf("%s[%0d]", name, i), outs(),
                  {vq[i].en, vq[i].ph, vq[i].busy, vq[i].done, vq[i].idx});
        end
        vq.delete();
    endtask

    initial begin
        RST = 1'b1;
        CE = 1'b0; START = 1'b0; STOP = 1'b0;
        cfg(0, 0, 0, 0);
        #12;
        check("reset_state", outs(), 12'h000);
        @(negedge CLK);
        RST = 1'b0;

        // Delay 3, on 4, single burst. add(ce,start,stop, en,ph,busy,done,idx)
        cfg(3, 4, 5, 1);
        add(1,1,0, 0,0,1,0,0);
        add(1,0,0, 0,0,1,0,0);
        add(1,0,0, 0,0,1,0,0);
        add(1,0,0, 1,1,1,0,0);
        add(1,0,0, 1,0,1,0,0);
        add(1,0,0, 1,0,1,0,0);
        add(1,0,0, 1,0,1,0,0);
        add(1,0,0, 0,0,0,1,0);
        add(1,0,0, 0,0,0,0,0);
        run_table("delay3_on4");

        // No delay, on 2, off 3, three bursts: 11000110001100.
        cfg(0, 2, 3, 3);
        add(1,1,0, 1,1,1,0,0);
        add(1,0,0, 1,0,1,0,0);
        add(1,0,0, 0,0,1,0,0);
        add(1,0,0, 0,0,1,0,0);
        add(1,0,0, 0,0,1,0,0);
        add(1,0,0, 1,1,1,0,1);
        add(1,0,0, 1,0,1,0,1);
        add(1,0,0, 0,0,1,0,1);
        add(1,0,0, 0,0,1,0,1);
        add(1,0,0, 0,0,1,0,1);
        add(1,0,0, 1,1,1,0,2);
        add(1,0,0, 1,0,1,0,2);
        add(1,0,0, 0,0,0,1,2);
        add(1,0,0, 0,0,0,0,2);
        run_table("off3_rep3");

        // Zero OFF gap: back-to-back ON, START while busy ignored.
        cfg(0, 2, 0, 2);
        add(1,1,0, 1,1,1,0,0);
        add(1,1,0, 1,0,1,0,0);
        add(1,0,0, 1,1,1,0,1);
        add(1,0,0, 1,0,1,0,1);
        add(1,0,0, 0,0,0,1,1);
        add(1,0,0, 0,0,0,0,1);
        run_table("off0_rep2");

        // CE toggling: everything advances on CE=1 edges only, holds otherwise.
        cfg(2, 2, 0, 1);
        add(0,1,0, 0,0,0,0,1);
        add(1,1,0, 0,0,1,0,0);
        add(0,0,0, 0,0,1,0,0);
        add(1,0,0, 0,0,1,0,0);
        add(0,0,0, 0,0,1,0,0);
        add(1,0,0, 1,1,1,0,0);
        add(0,0,0, 1,1,1,0,0);
        add(1,0,0, 1,0,1,0,0);
        add(0,0,0, 1,0,1,0,0);
        add(1,0,0, 0,0,0,1,0);
        add(0,0,0, 0,0,0,1,0);
        add(1,0,0, 0,0,0,0,0);
        run_table("ce_toggle");

        // STOP during DELAY; START+STOP together from IDLE does not start.
        cfg(5, 2, 0, 1);
        add(1,1,0, 0,0,1,0,0);
        add(1,0,0, 0,0,1,0,0);
        add(1,0,1, 0,0,0,0,0);
        add(1,1,1, 0,0,0,0,0);
        add(1,0,0, 0,0,0,0,0);
        run_table("stop_delay");

        // Infinite repeat, ON=1/OFF=1: bursts every 2 cycles, index wraps after 255.
        cfg(0, 1, 1, 0);
        for (int i = 0; i < 600; i++) begin
            step(1'b1, (i == 0), 1'b0);
            check($sformatf("inf[%0d]", i), outs(),
                  {(i % 2 == 0), (i % 2 == 0), 1'b1, 1'b0, REP_W'((i / 2) % 256)});
        end
        step(1'b1, 1'b1, 1'b1);
        check("inf_stop_start", outs(), {1'b0, 1'b0, 1'b0, 1'b0, REP_W'(299 % 256)});
        step(1'b1, 1'b0, 1'b0);
        check("inf_after_stop", outs(), {1'b0, 1'b0, 1'b0, 1'b0, REP_W'(299 % 256)});

        // Async reset mid-ON clears outputs without waiting for an edge.
        cfg(0, 8, 0, 1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("pre_rst_on", outs(), {1'b1, 1'b0, 1'b1, 1'b0, 8'd0});
        #2;
        RST = 1'b1;
        #1;
        check("rst_async", outs(), 12'h000);
        @(negedge CLK);
        RST = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        check("rst_release_idle", outs(), 12'h000);

        // START with ON_CYC=0 is ignored.
        cfg(0, 0, 2, 1);
        step(1'b1, 1'b1, 1'b0);
        check("on0_start", outs(), 12'h000);
        step(1'b1, 1'b0, 1'b0);
        check("on0_after", outs(), 12'h000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dds_burst_ctrl.md
Name: dds_burst_ctrl

Overview:
Burst scheduler for the DDS core output path. It generates a gated DDS enable window in four phases: a programmable start delay, then ON periods and OFF gaps, with a programmable repeat count. It also emits a phase-reset strobe at the start of each burst. It sits between the control register bank and the DDS accumulator/output enable, and replaces free-running enable with sequenced bursts.

Parameters:
CNT_W, 16, width of the delay/on/off cycle counters
REP_W, 8, width of the repeat count and burst index

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  reset, asynchronous, active-high
CE  in  1  clock enable; every state change and count is qualified by CE=1
START  in  1  request to start a burst sequence; sampled on CE edges
STOP  in  1  abort request; sampled on CE edges
DELAY_CYC  in  CNT_W  CE cycles from START to the first ON
ON_CYC  in  CNT_W  CE cycles per ON period; 0 is illegal
OFF_CYC  in  CNT_W  CE cycles per OFF gap between bursts
REPEAT  in  REP_W  number of bursts; 0 = infinite until STOP
DDS_EN  out  1  DDS output enable window, registered
PHASE_RST  out  1  high for the first CE cycle of every ON period, registered
BUSY  out  1  high in any state other than IDLE
DONE  out  1  high for one CE cycle after normal completion
BURST_IDX  out  REP_W  index of the current burst, starting at 0

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset: state IDLE. DDS_EN, PHASE_RST, BUSY and DONE are 0. BURST_IDX and all counters are 0.
- "Edge" below means a CLK rising edge with CE=1. When CE=0, state, counters and all outputs hold.
- States: IDLE, DELAY, ON, OFF. All outputs are registered; no combinational path from inputs to outputs.
- IDLE:
  - START=1 and ON_CYC!=0 → latch DELAY_CYC, ON_CYC, OFF_CYC and REPEAT; BURST_IDX=0; BUSY=1.
  - If DELAY_CYC=0, go directly to ON. Otherwise go to DELAY with cnt=DELAY_CYC.
  - START with ON_CYC=0 is ignored; stay in IDLE.
- Config inputs are ignored after they are latched; changes mid-sequence take effect at the next START only.
- DELAY: cnt decrements on each edge; at cnt=1 go to ON. DDS_EN rises exactly DELAY_CYC edges after the START edge; the same edge applies when DELAY_CYC=0.
- Entering ON: DDS_EN=1, PHASE_RST=1 for that CE cycle, cnt=ON_CYC. ON lasts exactly ON_CYC CE cycles.
- End of ON, last burst (REPEAT!=0 and BURST_IDX=REPEAT-1):
  - Go to IDLE with DDS_EN=0, BUSY=0, DONE=1.
  - DONE clears on the next edge.
  - No trailing OFF period.
- End of ON, not last burst:
  - OFF_CYC=0 → re-enter ON immediately. DDS_EN stays 1, PHASE_RST pulses again, BURST_IDX+1.
  - Otherwise go to OFF with DDS_EN=0 and cnt=OFF_CYC. After OFF_CYC CE cycles, enter ON with BURST_IDX+1.
- REPEAT=0: infinite bursts. BURST_IDX wraps modulo 2^REP_W; DONE never asserts.
- STOP=1 on an edge in any state → IDLE. DDS_EN=0, PHASE_RST=0, BUSY=0, DONE=0 on that edge; BURST_IDX holds its value.
- STOP and START on the same edge: STOP wins and no sequence starts.
- START while BUSY=1 is ignored and does not restart the sequence.
- RST asserted mid-sequence: outputs clear immediately. On RST release the block is in IDLE; START must be issued again.
- Counter widths: counts are unsigned CNT_W bits. The maximum value 2^CNT_W-1 must be supported without overflow.

Test Plan:
- DELAY_CYC=3, ON_CYC=4, REPEAT=1, CE=1, START on edge k → DDS_EN high on edges k+3..k+6 inclusive; PHASE_RST high 1 cycle at k+3; DONE high 1 cycle at k+7; BUSY high k..k+6.
- DELAY_CYC=0, ON_CYC=2, OFF_CYC=3, REPEAT=3 → DDS_EN pattern 11000110001100 starting at the START edge, then 0; BURST_IDX 0,1,2 at each ON entry; exactly one DONE pulse.
- OFF_CYC=0, ON_CYC=2, REPEAT=2 → DDS_EN high for 4 consecutive cycles; PHASE_RST pulses at cycle offsets 0 and 2; DONE at offset 4.
- CE toggling 1010…, DELAY_CYC=2, ON_CYC=2, REPEAT=1 → same transition sequence as with CE=1 but spread over CE-qualified edges only; outputs hold while CE=0.
- REPEAT=0, ON_CYC=1, OFF_CYC=1, run 600 cycles, then STOP together with START → BURST_IDX wraps 255→0; on the STOP edge DDS_EN=0 and BUSY=0, no DONE pulse, no restart.
- RST pulsed asynchronously mid-ON; separately, START with ON_CYC=0 → all outputs 0 immediately on RST, IDLE after release; START with ON_CYC=0 leaves BUSY=0.
